// File: rtl/half_duplex_bus_port_pkg.sv
// Shared types and widths for the half-duplex bus port.
package half_duplex_bus_port_pkg;

    localparam int TURN_W  = 4;
    localparam int BURST_W = 8;

    typedef enum logic [1:0] {
        LISTEN    = 2'd0,
        WAIT_IDLE = 2'd1,
        DRIVE     = 2'd2,
        RELEASE   = 2'd3
    } state_e;

endpackage

// File: rtl/half_duplex_bus_port_if.sv
// Local stream side of the half-duplex port: tx handshake, rx pulse, FSM debug.
// Handshake: a tx word moves on a rising clk edge where tx_valid && tx_ready;
// tx_ready is combinational and may drop without the word being taken.
// rx has no backpressure: rx_valid is a one-cycle pulse and rx_data holds.
interface half_duplex_bus_port_if #(
    parameter int DATA_W = 8
);
    import half_duplex_bus_port_pkg::*;

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    state_e            state_dbg;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, state_dbg
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, state_dbg
    );

endinterface

// File: rtl/half_duplex_bus_port_bus_tristate_pad.sv
// Bidirectional pad: the only tristate driver of the shared bus.
module bus_tristate_pad #(
    parameter int DATA_W = 8
) (
    inout  wire  [DATA_W-1:0] bus_io,
    input  logic              drv_en,
    input  logic [DATA_W-1:0] bus_q,
    output logic [DATA_W-1:0] bus_in
);

    // Drive the registered word only while enabled; otherwise float.
    assign bus_io = drv_en ? bus_q : {DATA_W{1'bz}};
    assign bus_in = bus_io;

endmodule

// File: rtl/half_duplex_bus_port.sv
// Bus-owner side of a two-party half-duplex tristate bus: waits for an idle
// bus, drives bursts, releases with turnaround, and receives peer words.
module half_duplex_bus_port
    import half_duplex_bus_port_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire  [DATA_W-1:0]    bus_io,
    output logic                 drv_en,
    output logic                 stb_o,
    input  logic                 peer_drv,
    input  logic                 stb_i,
    output logic                 err_coll,
    half_duplex_bus_port_if.slave stream
);

    localparam logic [TURN_W-1:0]  TURN_LIM  = TURN_W'(TURN_CYCLES);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    state_e               state_q, state_d;
    logic                 drv_en_q, drv_en_d;
    logic                 stb_o_q, stb_o_d;
    logic [DATA_W-1:0]    bus_q_q, bus_q_d;
    logic [TURN_W-1:0]    turn_cnt_q, turn_cnt_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]    rx_data_q, rx_data_d;
    logic                 err_coll_q, err_coll_d;
    logic [DATA_W-1:0]    bus_in;
    logic                 collision;
    logic                 tx_ready_c;
    logic [TURN_W-1:0]    turn_next;

    bus_tristate_pad #(.DATA_W(DATA_W)) u_pad (
        .bus_io (bus_io),
        .drv_en (drv_en_q),
        .bus_q  (bus_q_q),
        .bus_in (bus_in)
    );

    // Next-state, counters, transmit datapath, receive capture and collision flag.
    always_comb begin
        state_d     = state_q;
        drv_en_d    = drv_en_q;
        stb_o_d     = 1'b0;
        bus_q_d     = bus_q_q;
        turn_cnt_d  = turn_cnt_q;
        burst_cnt_d = burst_cnt_q;
        // Anyone else on the bus while we drive is a collision.
        collision   = drv_en_q && (peer_drv || stb_i);
        tx_ready_c  = (state_q == DRIVE) && !collision && (burst_cnt_q < BURST_LIM);
        turn_next   = (turn_cnt_q >= TURN_LIM) ? TURN_LIM : turn_cnt_q + TURN_W'(1);
        err_coll_d  = err_coll_q | collision;
        // Receive only while released; our own drive would alias the bus.
        rx_valid_d  = !drv_en_q && stb_i;
        rx_data_d   = rx_valid_d ? bus_in : rx_data_q;

        case (state_q)
            LISTEN: begin
                drv_en_d = 1'b0;
                if (stream.tx_valid) begin
                    state_d    = WAIT_IDLE;
                    turn_cnt_d = '0;
                end
            end
            WAIT_IDLE: begin
                if (peer_drv) begin
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_next;
                    if (turn_next >= TURN_LIM) begin
                        state_d  = DRIVE;
                        drv_en_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                // Burst limit is checked on the registered count so the last
                // word still gets its strobe cycle before release.
                if (collision || !stream.tx_valid || (burst_cnt_q >= BURST_LIM)) begin
                    state_d     = RELEASE;
                    drv_en_d    = 1'b0;
                    turn_cnt_d  = '0;
                    burst_cnt_d = '0;
                end else if (tx_ready_c) begin
                    bus_q_d     = stream.tx_data;
                    stb_o_d     = 1'b1;
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end
            end
            RELEASE: begin
                drv_en_d = 1'b0;
                if (turn_next >= TURN_LIM) begin
                    state_d    = LISTEN;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_next;
                end
            end
            default: begin
                state_d  = LISTEN;
                drv_en_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LISTEN;
            drv_en_q    <= 1'b0;
            stb_o_q     <= 1'b0;
            bus_q_q     <= '0;
            turn_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            err_coll_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drv_en_q    <= drv_en_d;
            stb_o_q     <= stb_o_d;
            bus_q_q     <= bus_q_d;
            turn_cnt_q  <= turn_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            err_coll_q  <= err_coll_d;
        end
    end

    assign drv_en           = drv_en_q;
    assign stb_o            = stb_o_q;
    assign err_coll         = err_coll_q;
    assign stream.tx_ready  = tx_ready_c;
    assign stream.rx_valid  = rx_valid_q;
    assign stream.rx_data   = rx_data_q;
    assign stream.state_dbg = state_q;

endmodule

// File: tb/tb_half_duplex_bus_port.sv
// Directed bench for half_duplex_bus_port (TURN_CYCLES=2, MAX_BURST=4).
module tb_half_duplex_bus_port;
    import half_duplex_bus_port_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       peer_drv;
    logic       stb_i;
    logic       peer_oe;
    logic [7:0] peer_data;
    logic       drv_en;
    logic       stb_o;
    logic       err_coll;
    wire  [7:0] bus_io;

    int n_tests;
    int n_fail;

    half_duplex_bus_port_if #(.DATA_W(8)) stream ();

    assign bus_io = peer_oe ? peer_data : 8'bz;

    half_duplex_bus_port #(
        .DATA_W      (8),
        .TURN_CYCLES (2),
        .MAX_BURST   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_io   (bus_io),
        .drv_en   (drv_en),
        .stb_o    (stb_o),
        .peer_drv (peer_drv),
        .stb_i    (stb_i),
        .err_coll (err_coll),
        .stream   (stream)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        peer_drv = 1'b0;
        stb_i = 1'b0;
        peer_oe = 1'b0;
        peer_data = 8'h00;
        stream.tx_valid = 1'b0;
        stream.tx_data  = 8'h00;

        // Reset state
        step();
        step();
        chk("rst_drv_en", 32'(drv_en), 32'd0);
        chk("rst_stb_o", 32'(stb_o), 32'd0);
        chk("rst_rx_valid", 32'(stream.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(stream.rx_data), 32'h00);
        chk("rst_err_coll", 32'(err_coll), 32'd0);
        chk("rst_state", 32'(stream.state_dbg), 32'(LISTEN));
        chk("rst_tx_ready", 32'(stream.tx_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // Receive one peer word in LISTEN
        peer_oe = 1'b1; peer_data = 8'h5A; peer_drv = 1'b1; stb_i = 1'b1;
        step();
        chk("rx_pulse", 32'(stream.rx_valid), 32'd1);
        chk("rx_data", 32'(stream.rx_data), 32'h5A);
        peer_oe = 1'b0; peer_drv = 1'b0; stb_i = 1'b0; peer_data = 8'h00;
        step();
        chk("rx_pulse_end", 32'(stream.rx_valid), 32'd0);
        chk("rx_data_hold", 32'(stream.rx_data), 32'h5A);

        // Three-word burst
        stream.tx_valid = 1'b1; stream.tx_data = 8'hA5;
        step();
        chk("b3_wait_state", 32'(stream.state_dbg), 32'(WAIT_IDLE));
        chk("b3_wait_drv0", 32'(drv_en), 32'd0);
        step();
        chk("b3_wait_drv1", 32'(drv_en), 32'd0);
        step();
        chk("b3_drv_en", 32'(drv_en), 32'd1);
        chk("b3_state_drive", 32'(stream.state_dbg), 32'(DRIVE));
        chk("b3_stb_pre", 32'(stb_o), 32'd0);
        chk("b3_tx_ready", 32'(stream.tx_ready), 32'd1);
        step();
        chk("b3_stb_w0", 32'(stb_o), 32'd1);
        chk("b3_bus_w0", 32'(bus_io), 32'hA5);
        stream.tx_data = 8'h3C;
        step();
        chk("b3_stb_w1", 32'(stb_o), 32'd1);
        chk("b3_bus_w1", 32'(bus_io), 32'h3C);
        stream.tx_data = 8'h7E;
        step();
        chk("b3_stb_w2", 32'(stb_o), 32'd1);
        chk("b3_bus_w2", 32'(bus_io), 32'h7E);
        stream.tx_valid = 1'b0;
        step();
        chk("b3_rel_drv", 32'(drv_en), 32'd0);
        chk("b3_rel_stb", 32'(stb_o), 32'd0);
        chk("b3_rel_state0", 32'(stream.state_dbg), 32'(RELEASE));
        step();
        chk("b3_rel_state1", 32'(stream.state_dbg), 32'(RELEASE));
        step();
        chk("b3_listen", 32'(stream.state_dbg), 32'(LISTEN));

        // Six words against a burst limit of four
        stream.tx_valid = 1'b1; stream.tx_data = 8'h10;
        step();
        step();
        step();
        chk("mb_drv_en", 32'(drv_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mb_stb", 32'(stb_o), 32'd1);
            chk("mb_bus", 32'(bus_io), 32'h10 + 32'(i));
            stream.tx_data = 8'h11 + 8'(i);
        end
        chk("mb_ready_lim", 32'(stream.tx_ready), 32'd0);
        step();
        chk("mb_rel_drv", 32'(drv_en), 32'd0);
        chk("mb_rel_stb", 32'(stb_o), 32'd0);
        chk("mb_rel_state", 32'(stream.state_dbg), 32'(RELEASE));
        step();
        chk("mb_rel_state1", 32'(stream.state_dbg), 32'(RELEASE));
        step();
        chk("mb_listen", 32'(stream.state_dbg), 32'(LISTEN));
        step();
        chk("mb_wait", 32'(stream.state_dbg), 32'(WAIT_IDLE));
        step();
        step();
        chk("mb_drv_again", 32'(drv_en), 32'd1);
        step();
        chk("mb_stb_w4", 32'(stb_o), 32'd1);
        chk("mb_bus_w4", 32'(bus_io), 32'h14);
        stream.tx_data = 8'h15;
        step();
        chk("mb_stb_w5", 32'(stb_o), 32'd1);
        chk("mb_bus_w5", 32'(bus_io), 32'h15);
        stream.tx_valid = 1'b0;
        step();
        chk("mb_end_drv", 32'(drv_en), 32'd0);
        step();
        step();
        chk("mb_end_listen", 32'(stream.state_dbg), 32'(LISTEN));

        // Collision on the second word of a burst
        stream.tx_valid = 1'b1; stream.tx_data = 8'h21;
        step();
        step();
        step();
        chk("co_drv_en", 32'(drv_en), 32'd1);
        step();
        chk("co_bus_w0", 32'(bus_io), 32'h21);
        stream.tx_data = 8'h22;
        peer_drv = 1'b1;
        #1;
        chk("co_tx_ready0", 32'(stream.tx_ready), 32'd0);
        chk("co_err_before", 32'(err_coll), 32'd0);
        step();
        chk("co_drv_off", 32'(drv_en), 32'd0);
        chk("co_err_set", 32'(err_coll), 32'd1);
        chk("co_stb_off", 32'(stb_o), 32'd0);
        chk("co_state_rel", 32'(stream.state_dbg), 32'(RELEASE));
        peer_drv = 1'b0;
        step();
        step();
        chk("co_listen", 32'(stream.state_dbg), 32'(LISTEN));
        step();
        step();
        step();
        chk("co_drv_again", 32'(drv_en), 32'd1);
        step();
        chk("co_resend_stb", 32'(stb_o), 32'd1);
        chk("co_resend_bus", 32'(bus_io), 32'h22);
        stream.tx_data = 8'h23;
        step();
        chk("co_bus_w2", 32'(bus_io), 32'h23);
        stream.tx_valid = 1'b0;
        step();
        chk("co_err_sticky", 32'(err_coll), 32'd1);
        step();
        step();
        chk("co_end_listen", 32'(stream.state_dbg), 32'(LISTEN));

        // Peer activity 1,0,1,0,0 during WAIT_IDLE, with one strobe received
        stream.tx_valid = 1'b1; stream.tx_data = 8'h31;
        step();
        chk("wi_state", 32'(stream.state_dbg), 32'(WAIT_IDLE));
        peer_drv = 1'b1;
        step();
        chk("wi_drv_a", 32'(drv_en), 32'd0);
        peer_drv = 1'b0;
        step();
        chk("wi_drv_b", 32'(drv_en), 32'd0);
        peer_drv = 1'b1; stb_i = 1'b1; peer_oe = 1'b1; peer_data = 8'h66;
        step();
        chk("wi_drv_c", 32'(drv_en), 32'd0);
        chk("wi_rx_valid", 32'(stream.rx_valid), 32'd1);
        chk("wi_rx_data", 32'(stream.rx_data), 32'h66);
        peer_drv = 1'b0; stb_i = 1'b0; peer_oe = 1'b0;
        step();
        chk("wi_drv_d", 32'(drv_en), 32'd0);
        chk("wi_state_d", 32'(stream.state_dbg), 32'(WAIT_IDLE));
        step();
        chk("wi_drv_on", 32'(drv_en), 32'd1);
        stream.tx_valid = 1'b0;
        step();
        chk("wi_rel", 32'(drv_en), 32'd0);
        step();
        step();
        chk("wi_listen", 32'(stream.state_dbg), 32'(LISTEN));

        // Asynchronous reset in the middle of a burst
        stream.tx_valid = 1'b1; stream.tx_data = 8'h41;
        step();
        step();
        step();
        step();
        chk("ar_pre_drv", 32'(drv_en), 32'd1);
        chk("ar_pre_stb", 32'(stb_o), 32'd1);
        chk("ar_pre_err", 32'(err_coll), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_drv_en", 32'(drv_en), 32'd0);
        chk("ar_stb_o", 32'(stb_o), 32'd0);
        chk("ar_err_coll", 32'(err_coll), 32'd0);
        chk("ar_state", 32'(stream.state_dbg), 32'(LISTEN));
        chk("ar_rx_data", 32'(stream.rx_data), 32'h00);
        stream.tx_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after_state", 32'(stream.state_dbg), 32'(LISTEN));
        chk("ar_after_drv", 32'(drv_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
